instr_sequencer: RTL and testbench

//  Multi-cycle control FSM for the 32-bit processor: fetches instructions, splits them into fields,
//  and sequences register-file reads, ALU operation and write-back. Owns the PC and branch decisions.

---
 rtl/instr_sequencer_pkg.sv | 50 +++++
 rtl/instr_sequencer_seq_pc.sv | 30 +++
 rtl/instr_sequencer.sv | 131 +++++++++++++
 tb/tb_instr_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer: opcodes,
// instruction field positions, FSM encoding and opcode classification helpers.
package instr_sequencer_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_MOV  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JNZ  = 4'hD;
  localparam logic [3:0] OP_RSVD = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 28;
  localparam int IMM_HI = 22;
  localparam int IMM_LO = 15;
  localparam int RD_HI  = 14;
  localparam int RD_LO  = 10;
  localparam int RS2_HI = 9;
  localparam int RS2_LO = 5;
  localparam int RS1_HI = 4;
  localparam int RS1_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  function automatic logic writes_rd(input logic [3:0] op);
    return is_alu_op(op) || (op == OP_LDI) || (op == OP_MOV);
  endfunction

endpackage

// File: rtl/instr_sequencer_seq_pc.sv
// Program counter: advances once per instruction, either to a jump target
// or to PC+1 with silent wrap at 2^PC_W.
module seq_pc
  import instr_sequencer_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            adv_i,
  input  logic            load_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (adv_i) pc_d = load_i ? target_i : pc_q + PC_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: fetch, decode (register read), execute (ALU control,
// branch decision) and write-back, plus ownership of the PC.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              imem_req_o,
  output logic [PC_W-1:0]   imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_rdata_i,
  output logic [4:0]        rf_raddr1_o,
  output logic [4:0]        rf_raddr2_o,
  input  logic [DATA_W-1:0] rf_rdata1_i,
  output logic              rf_we_o,
  output logic [4:0]        rf_waddr_o,
  output logic [3:0]        alu_op_o,
  output logic              alu_src_imm_o,
  output logic [DATA_W-1:0] imm_o,
  output logic              busy_o,
  output logic              halted_o,
  output logic              illegal_o
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        taken_q, taken_d;
  logic [PC_W-1:0] pc;

  logic [3:0] op;
  logic [7:0] imm8;
  logic [4:0] rd, rs1, rs2;
  logic       unused_ir;

  assign op        = ir_q[OP_HI:OP_LO];
  assign imm8      = ir_q[IMM_HI:IMM_LO];
  assign rd        = ir_q[RD_HI:RD_LO];
  assign rs2       = ir_q[RS2_HI:RS2_LO];
  assign rs1       = ir_q[RS1_HI:RS1_LO];
  assign unused_ir = ^ir_q[27:23];

  seq_pc #(.PC_W(PC_W)) u_pc (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .adv_i    (state_q == S_WB),
    .load_i   (taken_q),
    .target_i (PC_W'(imm8)),
    .pc_o     (pc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      taken_q <= taken_d;
    end
  end

  assign imem_addr_o = pc;

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    taken_d       = taken_q;
    imem_req_o    = 1'b0;
    rf_raddr1_o   = '0;
    rf_raddr2_o   = '0;
    rf_we_o       = 1'b0;
    rf_waddr_o    = '0;
    alu_op_o      = '0;
    alu_src_imm_o = 1'b0;
    imm_o         = '0;
    busy_o        = 1'b0;
    halted_o      = 1'b0;
    illegal_o     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_HALT: begin
        halted_o = 1'b1;
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy_o     = 1'b1;
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          ir_d    = imem_rdata_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        busy_o      = 1'b1;
        rf_raddr1_o = rs1;
        rf_raddr2_o = rs2;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        busy_o        = 1'b1;
        rf_raddr1_o   = rs1;
        rf_raddr2_o   = rs2;
        alu_op_o      = is_alu_op(op) ? op : 4'h0;
        alu_src_imm_o = (op == OP_LDI) || (op == OP_MOV);
        imm_o         = DATA_W'(imm8);
        illegal_o     = (op == OP_RSVD);
        // rs1 data arrives this cycle; capture the decision for the PC update in WB
        taken_d = (op == OP_JMP) ||
                  ((op == OP_JZ)  && (rf_rdata1_i == '0)) ||
                  ((op == OP_JNZ) && (rf_rdata1_i != '0));
        state_d = S_WB;
      end
      S_WB: begin
        busy_o     = 1'b1;
        rf_we_o    = writes_rd(op);
        rf_waddr_o = rd;
        state_d    = (op == OP_HALT) ? S_HALT : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: directed instruction sequence followed by random
// instructions, checked against an instruction-level model of PC and outputs.
module tb_instr_sequencer;
  localparam int PC_W   = 8;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst, start, imem_req, imem_ack, rf_we, alu_src_imm;
  logic              busy, halted, illegal;
  logic [PC_W-1:0]   imem_addr;
  logic [31:0]       imem_rdata;
  logic [4:0]        rf_raddr1, rf_raddr2, rf_waddr;
  logic [DATA_W-1:0] rf_rdata1, imm;
  logic [3:0]        alu_op;

  int n_chk = 0;
  int n_err = 0;
  logic [PC_W-1:0] m_pc;

  always #5 clk = ~clk;

  instr_sequencer #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (imem_ack),
    .imem_rdata_i (imem_rdata),
    .rf_raddr1_o  (rf_raddr1),
    .rf_raddr2_o  (rf_raddr2),
    .rf_rdata1_i  (rf_rdata1),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .alu_op_o     (alu_op),
    .alu_src_imm_o(alu_src_imm),
    .imm_o        (imm),
    .busy_o       (busy),
    .halted_o     (halted),
    .illegal_o    (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One instruction from FETCH through WB; the model advances m_pc at the end.
  task automatic exec_instr(input logic [31:0] w, input logic [DATA_W-1:0] rd1,
                            input int dly, input bit rst_exec);
    logic [3:0] op;
    logic [7:0] imm8;
    logic [4:0] rd, rs1, rs2;
    bit alu, wr, tk;
    logic [PC_W-1:0] nxt;
    op   = w[31:28];
    imm8 = w[22:15];
    rd   = w[14:10];
    rs2  = w[9:5];
    rs1  = w[4:0];
    alu  = (op >= 4'h1) && (op <= 4'h8);
    wr   = alu || (op == 4'h9) || (op == 4'hA);
    tk   = (op == 4'hB) || ((op == 4'hC) && (rd1 == '0)) || ((op == 4'hD) && (rd1 != '0));
    nxt  = tk ? PC_W'(imm8) : PC_W'(m_pc + PC_W'(1));

    for (int k = 0; k <= dly; k++) begin
      @(negedge clk);
      chk("fetch_req",  32'(imem_req), 32'd1);
      chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
      chk("fetch_busy", 32'(busy), 32'd1);
      chk("fetch_we",   32'(rf_we), 32'd0);
      start      = 1'($urandom_range(0, 1));
      imem_ack   = (k == dly);
      imem_rdata = (k == dly) ? w : $urandom;
    end

    @(negedge clk);
    chk("dec_raddr1", 32'(rf_raddr1), 32'(rs1));
    chk("dec_raddr2", 32'(rf_raddr2), 32'(rs2));
    chk("dec_req",    32'(imem_req), 32'd0);
    chk("dec_we",     32'(rf_we), 32'd0);
    imem_ack   = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    rf_rdata1  = rd1;

    @(negedge clk);
    chk("ex_raddr1",  32'(rf_raddr1), 32'(rs1));
    chk("ex_raddr2",  32'(rf_raddr2), 32'(rs2));
    chk("ex_alu_op",  32'(alu_op), alu ? 32'(op) : 32'd0);
    chk("ex_src_imm", 32'(alu_src_imm), 32'((op == 4'h9) || (op == 4'hA)));
    chk("ex_imm",     32'(imm), 32'(imm8));
    chk("ex_illegal", 32'(illegal), 32'(op == 4'hE));
    chk("ex_we",      32'(rf_we), 32'd0);
    start = 1'b0;
    if (rst_exec) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_we",   32'(rf_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pc",   32'(imem_addr), 32'd0);
      chk("rst_req",  32'(imem_req), 32'd0);
      m_pc = '0;
      return;
    end

    @(negedge clk);
    chk("wb_we",      32'(rf_we), 32'(wr));
    if (wr) chk("wb_waddr", 32'(rf_waddr), 32'(rd));
    chk("wb_illegal", 32'(illegal), 32'd0);
    chk("wb_busy",    32'(busy), 32'd1);
    rf_rdata1 = DATA_W'($urandom);
    imem_ack  = 1'($urandom_range(0, 1));
    m_pc = nxt;

    if (op == 4'hF) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_req",  32'(imem_req), 32'd0);
        chk("halt_busy", 32'(busy), 32'd0);
        chk("halt_we",   32'(rf_we), 32'd0);
        imem_ack = 1'b1;
      end
      imem_ack = 1'b0;
      start    = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [DATA_W-1:0] rd1;
    bit re;
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0; rf_rdata1 = '0;
    m_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req",     32'(imem_req), 32'd0);
    chk("rst_addr",    32'(imem_addr), 32'd0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_halted",  32'(halted), 32'd0);
    chk("rst_we",      32'(rf_we), 32'd0);
    chk("rst_alu_op",  32'(alu_op), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    imem_ack = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_req",  32'(imem_req), 32'd0);
    imem_ack = 1'b0;
    start = 1'b1;

    exec_instr(32'h9000_0405, 8'h11, 0, 1'b0);  // LDI r1, 0
    exec_instr(32'h1000_0C41, 8'h22, 0, 1'b0);  // ADD r3, r1, r2
    exec_instr(32'hC010_0000, 8'h00, 0, 1'b0);  // JZ 0x20 taken
    exec_instr(32'hC010_0000, 8'h05, 0, 1'b0);  // JZ 0x20 not taken
    exec_instr(32'h0000_0000, 8'h00, 3, 1'b0);  // NOP with slow memory
    exec_instr(32'hB07F_8000, 8'h00, 0, 1'b0);  // JMP 0xFF
    exec_instr(32'h0000_0000, 8'h00, 0, 1'b0);  // NOP at 0xFF -> wraps
    exec_instr(32'hE000_0000, 8'h00, 1, 1'b0);  // reserved
    exec_instr(32'hF000_0000, 8'h00, 0, 1'b0);  // HALT
    exec_instr(32'h0000_0000, 8'h00, 0, 1'b0);  // resumes after HALT
    exec_instr(32'h1000_0C41, 8'h00, 0, 1'b1);  // ADD, reset in EXEC
    start = 1'b1;

    for (int i = 0; i < 300; i++) begin
      w   = $urandom;
      rd1 = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom);
      re  = ($urandom_range(0, 39) == 0);
      exec_instr(w, rd1, int'($urandom_range(0, 3)), re);
      if (re) start = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
